// File: rtl/ram_bist_ctrl.sv
// RAM with built-in self-test: writes a mode-selected pattern to every word, reads it back and compares.
// Optional error injection on the write path is enabled by defining RAM_BIST_ERR_INJECT_EN.
module ram_bist_ctrl #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk_100,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] data_out
`ifdef RAM_BIST_ERR_INJECT_EN
  ,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr
`endif
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          mode_q;
  logic                at_last;
  logic                accept;
  logic                inj_hit;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rdata;
  logic                cmp_valid;
  logic [DATA_W-1:0]   exp_q;
  logic [ADDR_W-1:0]   cmp_addr_q;
  logic                mismatch;
  logic [DATA_W-1:0]   mem [DEPTH];

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
    logic [DATA_W+ADDR_W-1:0] wide;
    logic [DATA_W-1:0]        a_ext;
    logic [DATA_W-1:0]        alt;
    int unsigned              sh;
    wide  = {{DATA_W{1'b0}}, a};
    a_ext = wide[DATA_W-1:0];
    for (int i = 0; i < DATA_W; i++) alt[i] = ((DATA_W - 1 - i) % 2 == 0);
    sh = 32'(a) % 32'(DATA_W);
    case (m)
      2'd0:    pattern = a_ext;
      2'd1:    pattern = a[0] ? alt : ~alt;
      2'd2:    pattern = ~a_ext;
      default: pattern = DATA_W'(1) << sh;
    endcase
  endfunction

  assign at_last = (addr == LAST_ADDR);
  assign accept  = start && (state == IDLE || state == DONE);

`ifdef RAM_BIST_ERR_INJECT_EN
  assign inj_hit = inj_en && (addr == inj_addr);
`else
  assign inj_hit = 1'b0;
`endif

  assign wdata    = pattern(mode_q, addr) ^ {{(DATA_W-1){1'b0}}, inj_hit};
  assign mismatch = cmp_valid && (rdata != exp_q);

  // Memory contents survive reset on purpose; only the sequencer is cleared.
  always_ff @(posedge clk_100) begin
    if (state == WRITE) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = WRITE;
      WRITE: begin
        busy = 1'b1;
        if (at_last) state_next = READ;
      end
      READ: begin
        busy = 1'b1;
        if (at_last) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = WRITE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Expected word and address trail the read address by one cycle to meet the registered read data.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      addr           <= '0;
      mode_q         <= '0;
      cmp_valid      <= 1'b0;
      exp_q          <= '0;
      cmp_addr_q     <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
      data_out       <= '0;
    end else begin
      cmp_valid  <= (state == READ);
      exp_q      <= pattern(mode_q, addr);
      cmp_addr_q <= addr;
      if (accept) begin
        mode_q         <= mode;
        addr           <= '0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
      end else if (state == WRITE || state == READ) begin
        addr <= at_last ? '0 : addr + 1'b1;
      end
      if (cmp_valid) data_out <= rdata;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (err_cnt == '0) first_err_addr <= cmp_addr_q;
      end
      if (state == DRAIN) pass <= (err_cnt == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: randomized runs against an array-based reference model.
// Injection scenarios are exercised when RAM_BIST_ERR_INJECT_EN is defined.
module tb_ram_bist_ctrl;

  localparam int DW  = 4;
  localparam int AW  = 4;
  localparam int D16 = 16;
  localparam int D10 = 10;
  localparam int EW  = 8;

  logic          clk_100 = 1'b0;
  logic          rst_n;
  logic          start;
  logic          start10;
  logic [1:0]    mode;
  logic [1:0]    mode10;
  logic          busy, done, pass;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] data_out;
  logic          busy10, done10, pass10;
  logic [EW-1:0] err_cnt10;
  logic [AW-1:0] first_err_addr10;
  logic [DW-1:0] data_out10;
`ifdef RAM_BIST_ERR_INJECT_EN
  logic          inj_en;
  logic [AW-1:0] inj_addr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_100 = ~clk_100;

  ram_bist_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D16), .ERR_W(EW)) dut (
    .clk_100(clk_100), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .data_out(data_out)
`ifdef RAM_BIST_ERR_INJECT_EN
    , .inj_en(inj_en), .inj_addr(inj_addr)
`endif
  );

  ram_bist_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D10), .ERR_W(EW)) dut10 (
    .clk_100(clk_100), .rst_n(rst_n), .start(start10), .mode(mode10),
    .busy(busy10), .done(done10), .pass(pass10), .err_cnt(err_cnt10),
    .first_err_addr(first_err_addr10), .data_out(data_out10)
`ifdef RAM_BIST_ERR_INJECT_EN
    , .inj_en(1'b0), .inj_addr('0)
`endif
  );

  // Reference pattern from the arithmetic definition of each mode.
  function automatic int ref_pat(input int m, input int a);
    int mask;
    int alt;
    mask = (1 << DW) - 1;
    alt  = 0;
    for (int i = 0; i < DW; i++) alt = alt * 2 + ((i % 2 == 0) ? 1 : 0);
    case (m)
      0:       return a & mask;
      1:       return (a % 2 == 1) ? alt : (mask ^ alt);
      2:       return mask ^ (a & mask);
      default: return 1 << (a % DW);
    endcase
  endfunction

  task automatic run16(input int m, input bit noisy, input bit inj, input int inj_a, input string name);
    int  exp_mem[D16];
    int  exp_err, exp_first, exp_last, cycles, rises, budget;
    bit  seen, exp_pass;
    logic prev_done;
    exp_err = 0; exp_first = 0; seen = 1'b0;
    for (int a = 0; a < D16; a++)
      exp_mem[a] = ref_pat(m, a) ^ ((inj && a == inj_a) ? 1 : 0);
    for (int a = 0; a < D16; a++) begin
      if (exp_mem[a] != ref_pat(m, a)) begin
        if (!seen) exp_first = a;
        seen = 1'b1;
        exp_err++;
      end
    end
    if (exp_err > (1 << EW) - 1) exp_err = (1 << EW) - 1;
    exp_last = exp_mem[D16-1];
    exp_pass = (exp_err == 0);

    @(negedge clk_100);
    mode  = 2'(m);
    start = 1'b1;
`ifdef RAM_BIST_ERR_INJECT_EN
    inj_en   = inj;
    inj_addr = AW'(inj_a);
`endif
    @(negedge clk_100);
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s start_accept: got busy=%b done=%b expected busy=1 done=0", name, busy, done);
    end

    cycles = 0; rises = 0; budget = 0; prev_done = 1'b0;
    while (done !== 1'b1 && budget < 200) begin
      if (busy === 1'b1) cycles++;
      start = (noisy && busy === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk_100);
      budget++;
      if (done === 1'b1 && prev_done !== 1'b1) rises++;
      prev_done = done;
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk_100);
      if (done === 1'b1 && prev_done !== 1'b1) rises++;
      prev_done = done;
    end

    checks++;
    if (cycles != 2 * D16 + 1) begin
      errors++;
      $display("[TB] FAIL %s busy_len: got %0d expected %0d", name, cycles, 2 * D16 + 1);
    end
    checks++;
    if (rises != 1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s done_level: got rises=%0d done=%b busy=%b expected rises=1 done=1 busy=0", name, rises, done, busy);
    end
    checks++;
    if (pass !== exp_pass) begin
      errors++;
      $display("[TB] FAIL %s pass: got %b expected %b", name, pass, exp_pass);
    end
    checks++;
    if (err_cnt !== EW'(exp_err)) begin
      errors++;
      $display("[TB] FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
    end
    checks++;
    if (first_err_addr !== AW'(exp_first)) begin
      errors++;
      $display("[TB] FAIL %s first_err_addr: got %0d expected %0d", name, first_err_addr, exp_first);
    end
    checks++;
    if (data_out !== DW'(exp_last)) begin
      errors++;
      $display("[TB] FAIL %s data_out: got %h expected %h", name, data_out, exp_last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start10 = 1'b0; mode = 2'd0; mode10 = 2'd0;
`ifdef RAM_BIST_ERR_INJECT_EN
    inj_en = 1'b0; inj_addr = '0;
`endif
    #130;
    checks++;
    if ({busy, done, pass, err_cnt, first_err_addr, data_out} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b pass=%b err=%0d first=%0d data=%h expected all 0",
               busy, done, pass, err_cnt, first_err_addr, data_out);
    end
    rst_n = 1'b1;
    @(negedge clk_100);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    run16(1, 1'b0, 1'b0, 0, "b2b_mode1");
    run16(2, 1'b0, 1'b0, 0, "b2b_mode2");
    run16(3, 1'b0, 1'b0, 0, "b2b_mode3");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk_100);
    mode  = 2'd0;
    start = 1'b1;
    @(negedge clk_100);
    start = 1'b0;
    repeat (7) @(negedge clk_100);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, err_cnt, first_err_addr, data_out} !== '0) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b pass=%b err=%0d first=%0d data=%h expected all 0",
               busy, done, pass, err_cnt, first_err_addr, data_out);
    end
    @(negedge clk_100);
    rst_n = 1'b1;
    run16(0, 1'b0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_random();
    bit inj;
    for (int i = 0; i < 6; i++) begin
`ifdef RAM_BIST_ERR_INJECT_EN
      inj = 1'($urandom_range(0, 1));
`else
      inj = 1'b0;
`endif
      run16(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), inj, int'($urandom_range(0, D16 - 1)), "random");
    end
  endtask

  task automatic test_inject();
`ifdef RAM_BIST_ERR_INJECT_EN
    run16(0, 1'b0, 1'b1, 5, "inject_addr5");
    run16(0, 1'b0, 1'b0, 0, "inject_off");
`endif
  endtask

  task automatic test_depth10(input int m, input string name);
    int cycles, budget;
    @(negedge clk_100);
    mode10  = 2'(m);
    start10 = 1'b1;
    @(negedge clk_100);
    start10 = 1'b0;
    mode10  = 2'($urandom_range(0, 3));
    cycles = 0; budget = 0;
    while (done10 !== 1'b1 && budget < 200) begin
      if (busy10 === 1'b1) cycles++;
      @(negedge clk_100);
      budget++;
    end
    checks++;
    if (cycles != 2 * D10 + 1) begin
      errors++;
      $display("[TB] FAIL %s busy_len: got %0d expected %0d", name, cycles, 2 * D10 + 1);
    end
    checks++;
    if (pass10 !== 1'b1 || err_cnt10 !== '0 || first_err_addr10 !== '0) begin
      errors++;
      $display("[TB] FAIL %s result: got pass=%b err=%0d first=%0d expected 1 0 0", name, pass10, err_cnt10, first_err_addr10);
    end
    checks++;
    if (data_out10 !== DW'(ref_pat(m, D10 - 1))) begin
      errors++;
      $display("[TB] FAIL %s data_out: got %h expected %h", name, data_out10, ref_pat(m, D10 - 1));
    end
  endtask

  initial begin
    test_reset();
    run16(0, 1'b0, 1'b0, 0, "mode0");
    test_back_to_back();
    run16(int'($urandom_range(0, 3)), 1'b1, 1'b0, 0, "start_during_busy");
    test_reset_mid_run();
    test_inject();
    test_random();
    test_depth10(2, "depth10_mode2");
    test_depth10(int'($urandom_range(0, 3)), "depth10_random");
    test_depth10(int'($urandom_range(0, 3)), "depth10_random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
